plot_receiver: RTL and testbench

PLOT_RECEIVER -- requirements
Module: plot_receiver

---
 rtl/plot_receiver_pkg.sv | 54 +++++
 rtl/plot_fifo.sv | 70 +++++++
 rtl/plot_receiver.sv | 214 +++++++++++++++++++++
 tb/tb_plot_receiver.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_receiver_pkg.sv
// -----------------------------------------------------------------------------
// plot_receiver_pkg
//   Shared definitions for the plot receiver: FSM state enumeration, default
//   screen geometry, frame-buffer address width, the packed FIFO entry layout
//   and the pixel-to-address helper.
//   Macro PLOT_RECEIVER_CLEAR_EN adds the CLEAR state to the enumeration.
// -----------------------------------------------------------------------------
package plot_receiver_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int FB_ADDR_W    = 15;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  // One plot request as held in the FIFO: {x, y, col}, 18 bits.
  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] col;
  } plot_entry_t;

  localparam int ENTRY_W = $bits(plot_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1
`ifdef PLOT_RECEIVER_CLEAR_EN
    ,
    ST_CLEAR = 2'd2
`endif
  } state_t;

  // Linear frame address y*screen_w + x. The default 160-pixel width uses the
  // shift-add form 128y + 32y + x; the largest result (19199) fits in 15 bits.
  function automatic logic [FB_ADDR_W-1:0] frame_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y,
    input int             screen_w
  );
    logic [FB_ADDR_W-1:0] x_ext;
    logic [FB_ADDR_W-1:0] y_ext;
    x_ext = FB_ADDR_W'(x);
    y_ext = FB_ADDR_W'(y);
    if (screen_w == 160) begin
      return (y_ext << 7) + (y_ext << 5) + x_ext;
    end else begin
      return FB_ADDR_W'(int'(y) * screen_w + int'(x));
    end
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// -----------------------------------------------------------------------------
// plot_fifo
//   Synchronous FIFO for plot requests. A push is accepted only when the
//   count before the edge is below DEPTH; a pop in the same cycle does not
//   free a slot for that push. Push+pop together leave the count unchanged.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     push, push_data     write strobe and entry
//     pop                 read strobe (ignored when empty)
//     pop_data            head entry, valid while !empty
//     full, empty, count  occupancy
// -----------------------------------------------------------------------------
module plot_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptying the FIFO only needs the
  // pointers and count cleared, and a slot is always written before it is read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/plot_receiver.sv
// -----------------------------------------------------------------------------
// plot_receiver
//   Accepts pixel-plot requests into a small FIFO and drains them into a
//   registered frame-buffer write port. Off-screen requests are dropped and
//   flagged. With macro PLOT_RECEIVER_CLEAR_EN defined, a clear request fills
//   the whole frame with a latched colour; requests that arrive meanwhile wait
//   in the FIFO and are drained afterwards.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     enable                     low holds pops and frame-buffer writes
//     plot_go, x_in, y_in, col_in  plot request (one pixel per high cycle)
//     ready                      FIFO not full
//     clear_go, clear_col        clear request and fill colour (clear build)
//     fb_addr, fb_data, fb_we    registered frame-buffer write port
//     busy                       FIFO non-empty or clear pending/active
//     completed                  one-cycle pulse with the last clear write
//     clip_err, overflow         sticky error flags
// -----------------------------------------------------------------------------
module plot_receiver
  import plot_receiver_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 plot_go,
  input  logic [X_W-1:0]       x_in,
  input  logic [Y_W-1:0]       y_in,
  input  logic [COL_W-1:0]     col_in,
  output logic                 ready,
  input  logic                 clear_go,
  input  logic [COL_W-1:0]     clear_col,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COL_W-1:0]     fb_data,
  output logic                 fb_we,
  output logic                 busy,
  output logic                 completed,
  output logic                 clip_err,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q;
  state_t             state_d;
  plot_entry_t        push_entry;
  plot_entry_t        head;
  logic [ENTRY_W-1:0] head_bits;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_has_data;
  logic               pop;
  logic               head_in_range;

  assign push_entry = '{x: x_in, y: y_in, col: col_in};

  plot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (plot_go),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head          = head_bits;
  assign fifo_has_data = (fifo_count != '0);
  assign head_in_range = (int'(head.x) < SCREEN_W) && (int'(head.y) < SCREEN_H);
  assign ready         = !fifo_full;

`ifdef PLOT_RECEIVER_CLEAR_EN
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(SCREEN_W * SCREEN_H - 1);

  logic                 pending_q;
  logic [COL_W-1:0]     clr_col_q;
  logic [FB_ADDR_W-1:0] clr_cnt_q;
  logic                 completed_q;
  logic                 clr_write;
  logic                 clr_last;

  assign completed = completed_q;
  assign busy      = !fifo_empty || pending_q || (state_q == ST_CLEAR);
`else
  logic unused_clear_inputs;
  assign unused_clear_inputs = ^{clear_go, clear_col};
  assign completed           = 1'b0;
  assign busy                = !fifo_empty;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic. The pop that starts a drain is issued in the same IDLE
  // cycle that decides to enter DRAIN, so a request reaches fb_we two cycles
  // after its plot_go.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
`ifdef PLOT_RECEIVER_CLEAR_EN
    clr_write = 1'b0;
    clr_last  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
`ifdef PLOT_RECEIVER_CLEAR_EN
          // A pending clear wins over queued plots.
          if (pending_q) begin
            state_d = ST_CLEAR;
          end else if (fifo_has_data) begin
            state_d = ST_DRAIN;
            pop     = 1'b1;
          end
`else
          if (fifo_has_data) begin
            state_d = ST_DRAIN;
            pop     = 1'b1;
          end
`endif
        end
      end
      ST_DRAIN: begin
        if (enable) begin
          if (fifo_has_data) pop = 1'b1;
          else               state_d = ST_IDLE;
        end
      end
`ifdef PLOT_RECEIVER_CLEAR_EN
      ST_CLEAR: begin
        if (enable) begin
          clr_write = 1'b1;
          if (clr_cnt_q == LAST_ADDR) begin
            clr_last = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, write port and sticky flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_data  <= '0;
      clip_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      fb_we   <= 1'b0;
      if (pop) begin
        if (head_in_range) begin
          fb_we   <= 1'b1;
          fb_addr <= frame_addr(head.x, head.y, SCREEN_W);
          fb_data <= head.col;
        end else begin
          clip_err <= 1'b1;
        end
      end
`ifdef PLOT_RECEIVER_CLEAR_EN
      if (clr_write) begin
        fb_we   <= 1'b1;
        fb_addr <= clr_cnt_q;
        fb_data <= clr_col_q;
      end
`endif
      if (plot_go && fifo_full) overflow <= 1'b1;
    end
  end

`ifdef PLOT_RECEIVER_CLEAR_EN
  // ---------------------------------------------------------------------------
  // Clear engine: pending flag, latched colour and address counter. A new
  // clear_go is ignored while a clear is pending or running.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= 1'b0;
      clr_col_q   <= '0;
      clr_cnt_q   <= '0;
      completed_q <= 1'b0;
    end else begin
      completed_q <= clr_last;
      if (clr_write) begin
        clr_cnt_q <= clr_last ? '0 : clr_cnt_q + FB_ADDR_W'(1);
      end
      if (state_q == ST_IDLE && state_d == ST_CLEAR) begin
        pending_q <= 1'b0;
      end else if (clear_go && !pending_q && state_q != ST_CLEAR) begin
        pending_q <= 1'b1;
        clr_col_q <= clear_col;
      end
    end
  end
`endif

endmodule

// File: tb/tb_plot_receiver.sv
// -----------------------------------------------------------------------------
// tb_plot_receiver
//   Self-checking bench for plot_receiver. A monitor records every frame-buffer
//   write and completed pulse with a cycle stamp; a reference model derived
//   from the pixel rules (on-screen test, y*160+x, FIFO acceptance limit)
//   builds the expected write stream. Clear scenarios run only when
//   PLOT_RECEIVER_CLEAR_EN is defined.
// -----------------------------------------------------------------------------
module tb_plot_receiver;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int DEPTH = 4;
  localparam int NPIX  = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        plot_go;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  col_in;
  logic        ready;
  logic        clear_go;
  logic [2:0]  clear_col;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        busy;
  logic        completed;
  logic        clip_err;
  logic        overflow;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t obs[$];
  wr_t exp_q[$];
  int  comp_cyc[$];
  wr_t mon_w;
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  plot_receiver #(
    .SCREEN_W   (W),
    .SCREEN_H   (H),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .plot_go   (plot_go),
    .x_in      (x_in),
    .y_in      (y_in),
    .col_in    (col_in),
    .ready     (ready),
    .clear_go  (clear_go),
    .clear_col (clear_col),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_we     (fb_we),
    .busy      (busy),
    .completed (completed),
    .clip_err  (clip_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      mon_w.addr = int'(fb_addr);
      mon_w.data = int'(fb_data);
      mon_w.cyc  = cyc;
      obs.push_back(mon_w);
    end
    if (completed === 1'b1) comp_cyc.push_back(cyc);
  end

  // ---------------- reference model ----------------
  function automatic bit ref_on_screen(int x, int y);
    return (x < W) && (y < H);
  endfunction

  function automatic int ref_addr(int x, int y);
    return y * W + x;
  endfunction

  task automatic expect_plot(int x, int y, int c);
    wr_t w;
    if (ref_on_screen(x, y)) begin
      w.addr = ref_addr(x, y);
      w.data = c;
      w.cyc  = 0;
      exp_q.push_back(w);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_plot(bit go, int x, int y, int c);
    plot_go = go;
    x_in    = 8'(x);
    y_in    = 7'(y);
    col_in  = 3'(c);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vectors++; if (fb_we !== 1'b0)         begin miscompares++; $display("FAIL reset_fb_we got=%b exp=0", fb_we); end
    vectors++; if (fb_addr !== 15'd0)      begin miscompares++; $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr); end
    vectors++; if (fb_data !== 3'd0)       begin miscompares++; $display("FAIL reset_fb_data got=%0d exp=0", fb_data); end
    vectors++; if (completed !== 1'b0)     begin miscompares++; $display("FAIL reset_completed got=%b exp=0", completed); end
    vectors++; if (clip_err !== 1'b0)      begin miscompares++; $display("FAIL reset_clip_err got=%b exp=0", clip_err); end
    vectors++; if (overflow !== 1'b0)      begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    vectors++; if (busy !== 1'b0)          begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (ready !== 1'b1)         begin miscompares++; $display("FAIL reset_ready got=%b exp=1", ready); end
    reset = 1'b0;
    repeat (2) tick();
    vectors++; if (fb_we !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got fb_we=%b busy=%b exp 0/0", fb_we, busy); end
  endtask

  task automatic test_single();
    int t0;
    obs.delete();
    t0 = cyc;
    set_plot(1'b1, 5, 2, 3);
    tick();
    set_plot(1'b0, 0, 0, 0);
    repeat (6) tick();
    vectors++; if (obs.size() != 1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", obs.size()); end
    vectors++; if (obs.size() < 1 || obs[0].addr != 325) begin miscompares++; $display("FAIL single_addr got=%0d exp=325", obs.size() ? obs[0].addr : -1); end
    vectors++; if (obs.size() < 1 || obs[0].data != 3) begin miscompares++; $display("FAIL single_data got=%0d exp=3", obs.size() ? obs[0].data : -1); end
    vectors++; if (obs.size() < 1 || obs[0].cyc != t0 + 2) begin miscompares++; $display("FAIL single_latency got=%0d exp=%0d", obs.size() ? obs[0].cyc - t0 : -1, 2); end
  endtask

  task automatic test_overflow();
    int model_cnt;
    int x, y, c;
    bit ok;
    obs.delete();
    exp_q.delete();
    model_cnt = 0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = $urandom_range(0, W - 1);
      y = $urandom_range(0, H - 1);
      c = $urandom_range(0, 7);
      set_plot(1'b1, x, y, c);
      tick();
      if (model_cnt < DEPTH) begin
        expect_plot(x, y, c);
        model_cnt++;
      end
      vectors++; if (ready !== 1'(model_cnt < DEPTH)) begin miscompares++; $display("FAIL ovf_ready[%0d] got=%b exp=%b", i, ready, model_cnt < DEPTH); end
    end
    set_plot(1'b0, 0, 0, 0);
    repeat (3) tick();
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    vectors++; if (obs.size() != 0)   begin miscompares++; $display("FAIL ovf_held_writes got=%0d exp=0", obs.size()); end
    vectors++; if (busy !== 1'b1)     begin miscompares++; $display("FAIL ovf_busy_held got=%b exp=1", busy); end
    enable = 1'b1;
    wait_idle(50, ok);
    repeat (3) tick();
    vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_drain_timeout got=busy exp=idle"); end
    vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL ovf_write_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i].addr != exp_q[i].addr || obs[i].data != exp_q[i].data) begin
        miscompares++;
        $display("FAIL ovf_order[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, obs[i].addr, obs[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
    vectors++; if (clip_err !== 1'b0) begin miscompares++; $display("FAIL ovf_clip_clean got=%b exp=0", clip_err); end
  endtask

  task automatic test_clip();
    int x, y, c;
    bit ok;
    obs.delete();
    exp_q.delete();
    set_plot(1'b1, 160, 0, 5);
    tick();
    set_plot(1'b1, 0, 120, 2);
    tick();
    set_plot(1'b0, 0, 0, 0);
    repeat (6) tick();
    vectors++; if (obs.size() != 0)   begin miscompares++; $display("FAIL clip_no_write got=%0d exp=0", obs.size()); end
    vectors++; if (clip_err !== 1'b1) begin miscompares++; $display("FAIL clip_flag got=%b exp=1", clip_err); end
    vectors++; if (busy !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL clip_fifo_empty got busy=%b ready=%b exp 0/1", busy, ready); end
    // Mixed batch around the screen edges.
    for (int i = 0; i < 12; i++) begin
      x = $urandom_range(W - 4, W + 3);
      y = $urandom_range(H - 4, 127);
      c = $urandom_range(0, 7);
      set_plot(1'b1, x, y, c);
      expect_plot(x, y, c);
      tick();
    end
    set_plot(1'b0, 0, 0, 0);
    wait_idle(50, ok);
    repeat (3) tick();
    vectors++; if (!ok) begin miscompares++; $display("FAIL clip_drain_timeout got=busy exp=idle"); end
    vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL clip_batch_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i].addr != exp_q[i].addr || obs[i].data != exp_q[i].data) begin
        miscompares++;
        $display("FAIL clip_batch[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, obs[i].addr, obs[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    int x, y, c, n, model_cnt, base;
    bit ok;
    obs.delete();
    exp_q.delete();
    for (int round = 0; round < 12; round++) begin
      // Enabled phase: the FIFO drains as fast as it fills, so every push lands.
      enable = 1'b1;
      n = $urandom_range(5, 20);
      for (int i = 0; i < n; i++) begin
        x = $urandom_range(0, 175);
        y = $urandom_range(0, 127);
        c = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) begin
          set_plot(1'b1, x, y, c);
          expect_plot(x, y, c);
        end else begin
          set_plot(1'b0, x, y, c);
        end
        tick();
      end
      set_plot(1'b0, 0, 0, 0);
      repeat (4) tick();
      // Disabled phase: nothing pops, so only DEPTH of the burst are kept.
      base = obs.size();
      model_cnt = 0;
      enable = 1'b0;
      n = $urandom_range(2, 7);
      for (int i = 0; i < n; i++) begin
        x = $urandom_range(0, 175);
        y = $urandom_range(0, 127);
        c = $urandom_range(0, 7);
        set_plot(1'b1, x, y, c);
        tick();
        if (model_cnt < DEPTH) begin
          expect_plot(x, y, c);
          model_cnt++;
        end
        vectors++; if (ready !== 1'(model_cnt < DEPTH)) begin miscompares++; $display("FAIL rnd_ready r%0d i%0d got=%b exp=%b", round, i, ready, model_cnt < DEPTH); end
      end
      set_plot(1'b0, 0, 0, 0);
      tick();
      vectors++; if (obs.size() != base) begin miscompares++; $display("FAIL rnd_hold r%0d got=%0d exp=%0d", round, obs.size() - base, 0); end
      enable = 1'b1;
      wait_idle(50, ok);
      repeat (3) tick();
      vectors++; if (!ok) begin miscompares++; $display("FAIL rnd_drain_timeout r%0d got=busy exp=idle", round); end
    end
    vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd_write_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (obs[i].addr != exp_q[i].addr || obs[i].data != exp_q[i].data) begin
        miscompares++;
        $display("FAIL rnd_write[%0d] got addr=%0d data=%0d exp addr=%0d data=%0d", i, obs[i].addr, obs[i].data, exp_q[i].addr, exp_q[i].data);
      end
    end
  endtask

`ifdef PLOT_RECEIVER_CLEAR_EN
  task automatic test_clear();
    int px, py, pc, bad, first_bad;
    bit ok;
    obs.delete();
    comp_cyc.delete();
    clear_col = 3'd6;
    clear_go  = 1'b1;
    tick();
    clear_go  = 1'b0;
    clear_col = 3'd0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clear_busy got=%b exp=1", busy); end
    repeat (500) tick();
    px = $urandom_range(0, W - 1);
    py = $urandom_range(0, H - 1);
    pc = $urandom_range(0, 7);
    set_plot(1'b1, px, py, pc);
    tick();
    set_plot(1'b0, 0, 0, 0);
    repeat (500) tick();
    // A second request while the clear runs must be ignored.
    clear_col = 3'd1;
    clear_go  = 1'b1;
    tick();
    clear_go  = 1'b0;
    wait_idle(25000, ok);
    repeat (4) tick();
    vectors++; if (!ok) begin miscompares++; $display("FAIL clear_timeout got=busy exp=idle"); end
    vectors++; if (obs.size() != NPIX + 1) begin miscompares++; $display("FAIL clear_write_count got=%0d exp=%0d", obs.size(), NPIX + 1); end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < NPIX && i < obs.size(); i++) begin
      if (obs[i].addr != i || obs[i].data != 6) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL clear_pattern got %0d bad writes (first at %0d) exp 0", bad, first_bad); end
    vectors++; if (obs.size() <= NPIX || obs[NPIX].addr != ref_addr(px, py) || obs[NPIX].data != pc) begin
      miscompares++; $display("FAIL clear_held_plot got size=%0d exp addr=%0d data=%0d after clear", obs.size(), ref_addr(px, py), pc);
    end
    vectors++; if (comp_cyc.size() != 1) begin miscompares++; $display("FAIL clear_completed_count got=%0d exp=1", comp_cyc.size()); end
    vectors++; if (comp_cyc.size() < 1 || obs.size() <= NPIX || comp_cyc[0] < obs[NPIX-1].cyc || obs[NPIX].cyc <= comp_cyc[0]) begin
      miscompares++; $display("FAIL clear_order got completed/last-clear/plot order wrong exp last-clear <= completed < plot");
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clear_busy_drop got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit found;
    obs.delete();
    comp_cyc.delete();
    found = 1'b0;
    clear_col = 3'($urandom_range(1, 7));
    clear_go  = 1'b1;
    tick();
    clear_go  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (obs.size() > 0 && obs[obs.size()-1].addr == 1000) begin
        found = 1'b1;
        break;
      end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL abort_reach_1000 got=timeout exp=address 1000 written"); end
    reset = 1'b1;
    tick();
    vectors++; if (fb_we !== 1'b0)      begin miscompares++; $display("FAIL abort_fb_we got=%b exp=0", fb_we); end
    vectors++; if (fb_addr !== 15'd0)   begin miscompares++; $display("FAIL abort_fb_addr got=%0d exp=0", fb_addr); end
    vectors++; if (fb_data !== 3'd0)    begin miscompares++; $display("FAIL abort_fb_data got=%0d exp=0", fb_data); end
    vectors++; if (completed !== 1'b0)  begin miscompares++; $display("FAIL abort_completed got=%b exp=0", completed); end
    vectors++; if (clip_err !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL abort_flags got clip=%b ovf=%b exp 0/0", clip_err, overflow); end
    vectors++; if (busy !== 1'b0 || ready !== 1'b1) begin miscompares++; $display("FAIL abort_busy_ready got busy=%b ready=%b exp 0/1", busy, ready); end
    reset = 1'b0;
    n = obs.size();
    repeat (40) tick();
    vectors++; if (obs.size() != n)       begin miscompares++; $display("FAIL abort_no_writes got=%0d exp=0", obs.size() - n); end
    vectors++; if (comp_cyc.size() != 0)  begin miscompares++; $display("FAIL abort_no_completed got=%0d exp=0", comp_cyc.size()); end
  endtask
`else
  task automatic test_no_clear();
    obs.delete();
    comp_cyc.delete();
    clear_col = 3'd6;
    clear_go  = 1'b1;
    tick();
    clear_go  = 1'b0;
    repeat (20) tick();
    vectors++; if (obs.size() != 0)      begin miscompares++; $display("FAIL noclear_writes got=%0d exp=0", obs.size()); end
    vectors++; if (comp_cyc.size() != 0) begin miscompares++; $display("FAIL noclear_completed got=%0d exp=0", comp_cyc.size()); end
    vectors++; if (busy !== 1'b0)        begin miscompares++; $display("FAIL noclear_busy got=%b exp=0", busy); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    plot_go   = 1'b0;
    x_in      = '0;
    y_in      = '0;
    col_in    = '0;
    clear_go  = 1'b0;
    clear_col = '0;
    test_reset();
    test_single();
    test_overflow();
    test_clip();
    test_random();
`ifdef PLOT_RECEIVER_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_no_clear();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
